// File: rtl/md5_cracker_pkg.sv
// rtl/md5_cracker_pkg.sv - command codes, state enums and reset constants for the MD5 cracker
package md5_cracker_pkg;

  localparam logic [31:0] CMD_STOP         = 32'h5230_0000;
  localparam logic [31:0] CMD_START        = 32'h5230_0001;
  localparam logic [31:0] CMD_SET_EXP_A    = 32'h5230_1000;
  localparam logic [31:0] CMD_SET_EXP_B    = 32'h5230_1001;
  localparam logic [31:0] CMD_SET_EXP_C    = 32'h5230_1002;
  localparam logic [31:0] CMD_SET_EXP_D    = 32'h5230_1003;
  localparam logic [31:0] CMD_SET_RANGE    = 32'h5230_2000;
  localparam logic [31:0] CMD_GET_COUNT_LO = 32'h5230_3000;
  localparam logic [31:0] CMD_GET_COUNT_HI = 32'h5230_3001;
  localparam logic [31:0] CMD_GET_STATUS   = 32'h5230_4000;
  localparam logic [31:0] CMD_GET_TEXT0    = 32'h4400_0001;
  localparam logic [31:0] CMD_GET_TEXT1    = 32'h4400_0002;
  localparam logic [31:0] CMD_GET_TEXT2    = 32'h4400_0003;
  localparam logic [31:0] CMD_GET_TEXT3    = 32'h4400_0004;

  localparam logic [31:0] RST_EXP_A     = 32'h2971_bc83;
  localparam logic [31:0] RST_EXP_B     = 32'h9b41_f6a4;
  localparam logic [31:0] RST_EXP_C     = 32'h9556_20c0;
  localparam logic [31:0] RST_EXP_D     = 32'h9067_fbfd;
  localparam logic [7:0]  RST_RANGE_MIN = 8'h61;
  localparam logic [7:0]  RST_RANGE_MAX = 8'h7a;
  localparam logic [31:0] RSP_REJECT    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN_STOPPED = 2'd0,
    RUN_WARMUP  = 2'd1,
    RUN_RUNNING = 2'd2,
    RUN_FOUND   = 2'd3
  } run_state_e;

  typedef enum logic [2:0] {
    CS_WAIT      = 3'd0,
    CS_ARG_A     = 3'd1,
    CS_ARG_B     = 3'd2,
    CS_ARG_C     = 3'd3,
    CS_ARG_D     = 3'd4,
    CS_ARG_RANGE = 3'd5
  } cmd_state_e;

endpackage

// File: rtl/md5_multi_lane_cracker_if.sv
// rtl/md5_multi_lane_cracker_if.sv - command/response strobe bus of the MD5 cracker
interface md5_multi_lane_cracker_if;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output cmd_valid, output cmd_data, input rsp_valid, input rsp_data);
  modport slave  (input cmd_valid, input cmd_data, output rsp_valid, output rsp_data);
endinterface

// File: rtl/md5_text_delay.sv
// rtl/md5_text_delay.sv - fixed-depth shift register with per-stage valid bit
module md5_text_delay #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset2,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // shift every cycle; a flush drops all in-flight entries to invalid
  always_comb begin
    vld_d[0]  = in_valid;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    if (flush) vld_d = '0;
  end

  // valid bits are reset; payload is qualified by valid so it needs no reset
  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // payload stages
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/md5_multi_lane_cracker.sv
// rtl/md5_multi_lane_cracker.sv - command-driven control and match detection for parallel MD5 lanes
module md5_multi_lane_cracker
  import md5_cracker_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 64,
  parameter int CNT_W      = 64
) (
  input  logic                   clk,
  input  logic                   reset2,
  md5_multi_lane_cracker_if.slave bus,
  input  logic [LANES*128-1:0]   lane_text,
  input  logic [LANES*128-1:0]   lane_digest,
  output logic                   gen_reset,
  output logic [7:0]             range_min,
  output logic [7:0]             range_max,
  output logic                   matched
);

  cmd_state_e       cmd_state_q, cmd_state_d;
  run_state_e       run_state_q, run_state_d;
  logic [31:0]      warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             matched_q, matched_d;
  logic [3:0]       lane_idx_q, lane_idx_d;
  logic [127:0]     matched_text_q, matched_text_d;
  logic [31:0]      exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_c_q, exp_c_d, exp_d_q, exp_d_d;
  logic [7:0]       range_min_q, range_min_d, range_max_q, range_max_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;

  logic             stop_cmd, start_cmd;
  logic             gen_active;
  logic [LANES-1:0] dly_valid;
  logic [127:0]     dly_text [LANES];
  logic [LANES-1:0] hit;
  logic             hit_any;
  logic [3:0]       hit_idx;
  logic [127:0]     hit_text;
  logic [127:0]     exp_digest;
  logic [63:0]      count_ext;

  assign gen_active = (run_state_q != RUN_STOPPED);
  assign exp_digest = {exp_d_q, exp_c_q, exp_b_q, exp_a_q};
  assign count_ext  = 64'(count_q);

  // per-lane text delay so the text lines up with its digest at the core output
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    md5_text_delay #(.WIDTH(128), .DEPTH(PIPE_DEPTH)) u_dly (
      .clk      (clk),
      .reset2   (reset2),
      .flush    (stop_cmd),
      .in_valid (gen_active),
      .in_data  (lane_text[128*g +: 128]),
      .out_valid(dly_valid[g]),
      .out_data (dly_text[g])
    );
  end

  // compare every lane and pick the lowest hitting one
  always_comb begin
    hit      = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_text = '0;
    for (int i = 0; i < LANES; i++) begin
      hit[i] = dly_valid[i] && (lane_digest[128*i +: 128] == exp_digest);
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any  = 1'b1;
        hit_idx  = 4'(i);
        hit_text = dly_text[i];
      end
    end
  end

  // command decoder: one response per command, operands captured in ARG states
  always_comb begin
    cmd_state_d = cmd_state_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    exp_c_d     = exp_c_q;
    exp_d_d     = exp_d_q;
    range_min_d = range_min_q;
    range_max_d = range_max_q;
    rsp_valid_d = bus.cmd_valid;
    rsp_data_d  = '0;
    stop_cmd    = 1'b0;
    start_cmd   = 1'b0;
    if (bus.cmd_valid) begin
      case (cmd_state_q)
        CS_WAIT: begin
          case (bus.cmd_data)
            CMD_STOP:         stop_cmd = 1'b1;
            CMD_START:        start_cmd = 1'b1;
            CMD_SET_EXP_A:    cmd_state_d = CS_ARG_A;
            CMD_SET_EXP_B:    cmd_state_d = CS_ARG_B;
            CMD_SET_EXP_C:    cmd_state_d = CS_ARG_C;
            CMD_SET_EXP_D:    cmd_state_d = CS_ARG_D;
            CMD_SET_RANGE:    cmd_state_d = CS_ARG_RANGE;
            CMD_GET_COUNT_LO: rsp_data_d = count_ext[31:0];
            CMD_GET_COUNT_HI: rsp_data_d = count_ext[63:32];
            CMD_GET_STATUS:   rsp_data_d = {matched_q, 3'b000, lane_idx_q, 22'd0, run_state_q};
            CMD_GET_TEXT0:    rsp_data_d = matched_text_q[31:0];
            CMD_GET_TEXT1:    rsp_data_d = matched_text_q[63:32];
            CMD_GET_TEXT2:    rsp_data_d = matched_text_q[95:64];
            CMD_GET_TEXT3:    rsp_data_d = matched_text_q[127:96];
            default:          rsp_data_d = '0;
          endcase
        end
        CS_ARG_A: begin exp_a_d = bus.cmd_data; cmd_state_d = CS_WAIT; end
        CS_ARG_B: begin exp_b_d = bus.cmd_data; cmd_state_d = CS_WAIT; end
        CS_ARG_C: begin exp_c_d = bus.cmd_data; cmd_state_d = CS_WAIT; end
        CS_ARG_D: begin exp_d_d = bus.cmd_data; cmd_state_d = CS_WAIT; end
        CS_ARG_RANGE: begin
          if (bus.cmd_data[7:0] > bus.cmd_data[15:8]) begin
            rsp_data_d = RSP_REJECT;
          end else begin
            range_min_d = bus.cmd_data[7:0];
            range_max_d = bus.cmd_data[15:8];
          end
          cmd_state_d = CS_WAIT;
        end
        default: cmd_state_d = CS_WAIT;
      endcase
    end
  end

  // run control: warmup, counting, match capture; STOP overrides everything
  always_comb begin
    run_state_d    = run_state_q;
    warm_cnt_d     = warm_cnt_q;
    count_d        = count_q;
    matched_d      = matched_q;
    lane_idx_d     = lane_idx_q;
    matched_text_d = matched_text_q;
    case (run_state_q)
      RUN_STOPPED: begin
        if (start_cmd) begin
          run_state_d = RUN_WARMUP;
          warm_cnt_d  = '0;
        end
      end
      RUN_WARMUP: begin
        if (warm_cnt_q == 32'(PIPE_DEPTH - 1)) run_state_d = RUN_RUNNING;
        else                                   warm_cnt_d  = warm_cnt_q + 32'd1;
      end
      RUN_RUNNING: begin
        count_d = count_q + CNT_W'(LANES);
        if (hit_any) begin
          run_state_d    = RUN_FOUND;
          matched_d      = 1'b1;
          lane_idx_d     = hit_idx;
          matched_text_d = hit_text;
        end
      end
      default: ;
    endcase
    if (stop_cmd) begin
      run_state_d    = RUN_STOPPED;
      count_d        = '0;
      matched_d      = 1'b0;
      matched_text_d = '0;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      cmd_state_q    <= CS_WAIT;
      run_state_q    <= RUN_STOPPED;
      warm_cnt_q     <= '0;
      count_q        <= '0;
      matched_q      <= 1'b0;
      lane_idx_q     <= '0;
      matched_text_q <= '0;
      exp_a_q        <= RST_EXP_A;
      exp_b_q        <= RST_EXP_B;
      exp_c_q        <= RST_EXP_C;
      exp_d_q        <= RST_EXP_D;
      range_min_q    <= RST_RANGE_MIN;
      range_max_q    <= RST_RANGE_MAX;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      cmd_state_q    <= cmd_state_d;
      run_state_q    <= run_state_d;
      warm_cnt_q     <= warm_cnt_d;
      count_q        <= count_d;
      matched_q      <= matched_d;
      lane_idx_q     <= lane_idx_d;
      matched_text_q <= matched_text_d;
      exp_a_q        <= exp_a_d;
      exp_b_q        <= exp_b_d;
      exp_c_q        <= exp_c_d;
      exp_d_q        <= exp_d_d;
      range_min_q    <= range_min_d;
      range_max_q    <= range_max_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign gen_reset     = ~gen_active;
  assign range_min     = range_min_q;
  assign range_max     = range_max_q;
  assign matched       = matched_q;

endmodule

// File: tb/tb_md5_multi_lane_cracker.sv
// tb/tb_md5_multi_lane_cracker.sv - scoreboard bench for the MD5 multi-lane cracker
module tb_md5_multi_lane_cracker;
  import md5_cracker_pkg::*;

  localparam int LANES = 4;
  localparam int P     = 8;
  localparam int CNT_W = 64;

  logic clk = 1'b0;
  logic reset2;
  logic [LANES*128-1:0] lane_text, lane_digest;
  logic gen_reset, matched;
  logic [7:0] range_min, range_max;

  always #5 clk = ~clk;

  md5_multi_lane_cracker_if bus ();

  md5_multi_lane_cracker #(.LANES(LANES), .PIPE_DEPTH(P), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset2     (reset2),
    .bus        (bus),
    .lane_text  (lane_text),
    .lane_digest(lane_digest),
    .gen_reset  (gen_reset),
    .range_min  (range_min),
    .range_max  (range_max),
    .matched    (matched)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  localparam logic [127:0] DIG_1234 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] DIG_RST  = {RST_EXP_D, RST_EXP_C, RST_EXP_B, RST_EXP_A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // response monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset2 && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%08h, required no response", bus.rsp_data);
      end else begin
        check(name_q.pop_front(), bus.rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] word, input logic [31:0] rsp, input string name);
    exp_q.push_back(rsp);
    name_q.push_back(name);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = word;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
  endtask

  // text enters the core this cycle; its digest appears P cycles later
  task automatic inject(input logic [LANES-1:0] mask, input logic [127:0] base, input logic [127:0] dig);
    for (int i = 0; i < LANES; i++) if (mask[i]) lane_text[128*i +: 128] = base + 128'(i);
    @(posedge clk);
    @(negedge clk);
    lane_text = '0;
    idle(P - 1);
    for (int i = 0; i < LANES; i++) if (mask[i]) lane_digest[128*i +: 128] = dig;
    @(posedge clk);
    @(negedge clk);
    lane_digest = '0;
  endtask

  initial begin
    reset2        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    lane_text     = '0;
    lane_digest   = '0;
    idle(3);
    reset2 = 1'b0;
    idle(1);

    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_gen_reset", 32'(gen_reset), 32'd1);
    check("reset_matched", 32'(matched), 32'd0);
    check("reset_range_min", 32'(range_min), 32'h61);
    check("reset_range_max", 32'(range_max), 32'h7a);
    send(CMD_GET_COUNT_LO, 32'd0, "reset_count_lo");
    send(CMD_GET_STATUS, 32'd0, "reset_status");

    send(CMD_SET_RANGE, 32'd0, "set_range_cmd");
    send(32'h0000_417A, 32'hFFFF_FFFF, "range_reject_rsp");
    check("range_reject_min", 32'(range_min), 32'h61);
    check("range_reject_max", 32'(range_max), 32'h7a);
    send(CMD_SET_RANGE, 32'd0, "set_range_cmd2");
    send(32'h0000_7A41, 32'd0, "range_accept_rsp");
    check("range_accept_min", 32'(range_min), 32'h41);
    check("range_accept_max", 32'(range_max), 32'h7a);

    send(CMD_SET_EXP_A, 32'd0, "set_exp_a"); send(32'd1, 32'd0, "exp_a_op");
    send(CMD_SET_EXP_B, 32'd0, "set_exp_b"); send(32'd2, 32'd0, "exp_b_op");
    send(CMD_SET_EXP_C, 32'd0, "set_exp_c"); send(32'd3, 32'd0, "exp_c_op");
    send(CMD_SET_EXP_D, 32'd0, "set_exp_d"); send(32'd4, 32'd0, "exp_d_op");
    send(CMD_START, 32'd0, "start1");
    check("start_gen_reset", 32'(gen_reset), 32'd0);
    idle(P);
    idle(10);
    inject(4'b0100, 128'h0061_6261, DIG_1234);
    check("match_flag", 32'(matched), 32'd1);
    send(CMD_GET_COUNT_LO, 32'd4 * 32'(11 + P), "match_count_lo");
    send(CMD_GET_STATUS, 32'h8200_0003, "match_status_lane2");
    send(CMD_GET_TEXT0, 32'h0061_6263, "match_text0");
    send(CMD_GET_TEXT1, 32'd0, "match_text1");
    send(32'h1234_5678, 32'd0, "unknown_cmd_noop");

    send(CMD_STOP, 32'd0, "stop1");
    check("stop_matched", 32'(matched), 32'd0);
    send(CMD_START, 32'd0, "start2");
    idle(P);
    inject(4'b1010, 128'h1000, DIG_1234);
    send(CMD_GET_STATUS, 32'h8100_0003, "two_hit_status_lane1");
    send(CMD_GET_TEXT0, 32'h0000_1001, "two_hit_text0");
    inject(4'b0001, 128'hAAAA, DIG_1234);
    send(CMD_GET_STATUS, 32'h8100_0003, "late_hit_status");
    send(CMD_GET_TEXT0, 32'h0000_1001, "late_hit_text0");

    send(CMD_STOP, 32'd0, "stop2");
    send(CMD_START, 32'd0, "start3");
    idle(P + 100);
    send(CMD_GET_COUNT_LO, 32'd400, "count_100_cycles");
    send(CMD_GET_COUNT_HI, 32'd0, "count_hi");
    send(CMD_STOP, 32'd0, "stop3");
    send(CMD_GET_COUNT_LO, 32'd0, "count_after_stop");
    check("stop_gen_reset", 32'(gen_reset), 32'd1);

    send(CMD_SET_EXP_B, 32'd0, "set_exp_b_abort");
    idle(1);
    reset2 = 1'b1;
    idle(2);
    reset2 = 1'b0;
    idle(1);
    check("abort_range_min", 32'(range_min), 32'h61);
    check("abort_gen_reset", 32'(gen_reset), 32'd1);
    send(CMD_START, 32'd0, "abort_start");
    send(CMD_GET_STATUS, 32'h0000_0001, "abort_status_warmup");
    idle(P - 1);
    inject(4'b0001, 128'h5555, DIG_RST);
    send(CMD_GET_STATUS, 32'h8000_0003, "reset_digest_status");
    send(CMD_GET_TEXT0, 32'h0000_5555, "reset_digest_text0");

    idle(3);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
